// File: rtl/syllable_serializer.sv
// syllable_serializer
//
// Bit-serial output stage that sits directly after the core memory. A load
// pulse captures one 14-bit syllable from the sense amplifiers (13 data bits
// plus an odd-parity bit). The data bits are then shifted out LSB first, one
// bit per bit-time enable, towards the serial arithmetic section. A parallel
// copy of the data and a parity-error flag remain available for the
// error-detection logic until the next load.
//
// Optional feature macro: SYLLABLE_PARITY_CHECK_EN
//   defined   : odd parity over all 14 bits is checked and PERR is registered.
//   undefined : no parity logic; PERR is tied low and MmSA14 is ignored.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset          synchronous, active-high reset
//   MmSA1..MmSA13  sense-amp data bits (MmSA1 is the LSB)
//   MmSA14         sense-amp parity bit
//   LOADV          one-cycle load request, samples MmSA1..MmSA14
//   BITEN          bit-time enable, advances the serializer by one bit
//   SDATA          current serial data bit (0 when idle)
//   BUSY           high while unshifted bits remain
//   DONE           one-cycle pulse after the 13th bit is consumed
//   PDATA          parallel copy of the captured data bits
//   PERR           parity error for the captured syllable

module syllable_serializer #(
    parameter int DATA_BITS = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MmSA1,
    input  logic                 MmSA2,
    input  logic                 MmSA3,
    input  logic                 MmSA4,
    input  logic                 MmSA5,
    input  logic                 MmSA6,
    input  logic                 MmSA7,
    input  logic                 MmSA8,
    input  logic                 MmSA9,
    input  logic                 MmSA10,
    input  logic                 MmSA11,
    input  logic                 MmSA12,
    input  logic                 MmSA13,
    input  logic                 MmSA14,
    input  logic                 LOADV,
    input  logic                 BITEN,
    output logic                 SDATA,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [DATA_BITS-1:0] PDATA,
    output logic                 PERR
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] pdata_q, pdata_d;
    logic [3:0]           count_q, count_d;
    logic                 done_q,  done_d;
    logic [DATA_BITS-1:0] captured;

    assign captured = {MmSA13, MmSA12, MmSA11, MmSA10, MmSA9, MmSA8, MmSA7,
                       MmSA6, MmSA5, MmSA4, MmSA3, MmSA2, MmSA1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            pdata_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // A load always wins over a coincident bit enable, so a load landing on
    // the terminal bit restarts the syllable and swallows that DONE. The
    // terminal test uses >= so a corrupted counter still falls back to IDLE.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        pdata_d = pdata_q;
        count_d = count_q;
        done_d  = 1'b0;

        if (LOADV) begin
            state_d = SHIFT;
            shift_d = captured;
            pdata_d = captured;
            count_d = '0;
        end else if (state_q == SHIFT && BITEN) begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            if (count_q >= LAST_BIT) begin
                state_d = IDLE;
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    // The register is zero-filled from the top, so after the 13th shift (and
    // after reset) bit 0 is already 0; SDATA can come straight off the flop.
    assign SDATA = shift_q[0];
    assign BUSY  = (state_q == SHIFT);
    assign DONE  = done_q;
    assign PDATA = pdata_q;

`ifdef SYLLABLE_PARITY_CHECK_EN
    logic parity_err;
    logic perr_q;

    // Odd parity: the XOR of all 14 bits must be 1. An all-zero syllable
    // (memory blanked during its strobe) therefore always flags an error.
    assign parity_err = ~(^{MmSA14, captured});

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if (LOADV) begin
            perr_q <= parity_err;
        end
    end

    assign PERR = perr_q;
`else
    logic unused_parity_bit;

    assign unused_parity_bit = MmSA14;
    assign PERR              = 1'b0;
`endif

endmodule

// File: tb/tb_syllable_serializer.sv
// tb_syllable_serializer
//
// Self-checking bench for syllable_serializer. Each load pushes the expected
// SDATA sequence (13 data bits, then the trailing 0) into a queue; every time
// the DUT presents a new bit (after the load and after each BITEN) the front
// entry is popped and compared against SDATA. Expected PDATA/PERR come from a
// small model evaluated when the syllable is driven.

module tb_syllable_serializer;

    logic        clk;
    logic        reset;
    logic [13:0] syl;
    logic        LOADV;
    logic        BITEN;
    logic        SDATA;
    logic        BUSY;
    logic        DONE;
    logic [12:0] PDATA;
    logic        PERR;

    int checks   = 0;
    int failures = 0;

    logic        exp_bits[$];
    logic [12:0] exp_pdata;
    logic        exp_perr;

    syllable_serializer #(.DATA_BITS(13)) dut (
        .clk    (clk),
        .reset  (reset),
        .MmSA1  (syl[0]),
        .MmSA2  (syl[1]),
        .MmSA3  (syl[2]),
        .MmSA4  (syl[3]),
        .MmSA5  (syl[4]),
        .MmSA6  (syl[5]),
        .MmSA7  (syl[6]),
        .MmSA8  (syl[7]),
        .MmSA9  (syl[8]),
        .MmSA10 (syl[9]),
        .MmSA11 (syl[10]),
        .MmSA12 (syl[11]),
        .MmSA13 (syl[12]),
        .MmSA14 (syl[13]),
        .LOADV  (LOADV),
        .BITEN  (BITEN),
        .SDATA  (SDATA),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .PDATA  (PDATA),
        .PERR   (PERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference parity model: odd parity over all 14 bits.
    function automatic logic model_perr(input logic [13:0] s);
`ifdef SYLLABLE_PARITY_CHECK_EN
        return ~(^s);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one clock of stimulus, then sample 1 time unit after the edge.
    task automatic cycle(input logic rst, input logic ld, input logic be);
        @(negedge clk);
        reset = rst;
        LOADV = ld;
        BITEN = be;
        @(posedge clk);
        #1;
        reset = 1'b0;
        LOADV = 1'b0;
        BITEN = 1'b0;
    endtask

    // Set up the scoreboard for a syllable about to be loaded.
    task automatic expect_syllable(input logic [12:0] d, input logic p14);
        syl       = {p14, d};
        exp_pdata = d;
        exp_perr  = model_perr({p14, d});
        exp_bits.delete();
        for (int i = 0; i < 13; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({SDATA, BUSY, DONE, PERR} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {SDATA, BUSY, DONE, PERR});
        end
        checks++;
        if (PDATA !== 13'h0000) begin
            failures++;
            $display("[TB] FAIL reset_pdata: got %h expected 0000", PDATA);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if ({DONE, BUSY, SDATA} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL idle_biten: got done/busy/sdata=%b expected 000", {DONE, BUSY, SDATA});
            end
        end
    endtask

    // Load one syllable and shift it out with 'gap' idle cycles between
    // BITENs, checking every bit, BUSY between bits and a single DONE.
    task automatic test_stream(input string label, input logic [12:0] d,
                               input logic p14, input int gap);
        logic cur;
        int   dones;
        expect_syllable(d, p14);
        cycle(1'b0, 1'b1, 1'b0);
        cur = exp_bits.pop_front();
        checks++;
        if ({SDATA, BUSY, DONE} !== {cur, 2'b10}) begin
            failures++;
            $display("[TB] FAIL %s_load: got sdata/busy/done=%b expected %b", label, {SDATA, BUSY, DONE}, {cur, 2'b10});
        end
        checks++;
        if (PDATA !== exp_pdata || PERR !== exp_perr) begin
            failures++;
            $display("[TB] FAIL %s_capture: got pdata=%h perr=%b expected pdata=%h perr=%b", label, PDATA, PERR, exp_pdata, exp_perr);
        end
        dones = 0;
        for (int i = 0; i < 13; i++) begin
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 1'b0, 1'b0);
                checks++;
                if ({SDATA, BUSY, DONE} !== {cur, 2'b10}) begin
                    failures++;
                    $display("[TB] FAIL %s_hold%0d: got sdata/busy/done=%b expected %b", label, i, {SDATA, BUSY, DONE}, {cur, 2'b10});
                end
            end
            cycle(1'b0, 1'b0, 1'b1);
            if (DONE === 1'b1) dones++;
            cur = exp_bits.pop_front();
            checks++;
            if (SDATA !== cur || BUSY !== (i < 12)) begin
                failures++;
                $display("[TB] FAIL %s_bit%0d: got sdata=%b busy=%b expected sdata=%b busy=%b", label, i + 1, SDATA, BUSY, cur, (i < 12));
            end
        end
        cycle(1'b0, 1'b0, 1'b0);
        if (DONE === 1'b1) dones++;
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("[TB] FAIL %s_done_count: got %0d expected 1", label, dones);
        end
        checks++;
        if ({SDATA, BUSY, DONE} !== 3'b000 || PDATA !== exp_pdata || PERR !== exp_perr) begin
            failures++;
            $display("[TB] FAIL %s_after: got sdata/busy/done=%b pdata=%h perr=%b expected 000 pdata=%h perr=%b", label, {SDATA, BUSY, DONE}, PDATA, PERR, exp_pdata, exp_perr);
        end
    endtask

    task automatic test_restart();
        logic cur;
        int   dones;
        expect_syllable(13'h0001, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cur = exp_bits.pop_front();
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            cur = exp_bits.pop_front();
            checks++;
            if (SDATA !== cur || BUSY !== 1'b1) begin
                failures++;
                $display("[TB] FAIL restart_first_bit%0d: got sdata=%b busy=%b expected sdata=%b busy=1", i + 2, SDATA, BUSY, cur);
            end
        end
        expect_syllable(13'h1FFF, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cur = exp_bits.pop_front();
        checks++;
        if ({SDATA, BUSY, DONE} !== {cur, 2'b10} || PDATA !== exp_pdata || PERR !== exp_perr) begin
            failures++;
            $display("[TB] FAIL restart_load: got sdata/busy/done=%b pdata=%h perr=%b expected %b pdata=%h perr=%b", {SDATA, BUSY, DONE}, PDATA, PERR, {cur, 2'b10}, exp_pdata, exp_perr);
        end
        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            if (DONE === 1'b1) begin
                dones++;
                checks++;
                if (i !== 12) begin
                    failures++;
                    $display("[TB] FAIL restart_done_position: got after biten %0d expected after biten 13", i + 1);
                end
            end
            cur = exp_bits.pop_front();
            checks++;
            if (SDATA !== cur) begin
                failures++;
                $display("[TB] FAIL restart_bit%0d: got %b expected %b", i + 1, SDATA, cur);
            end
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("[TB] FAIL restart_done_count: got %0d expected 1", dones);
        end
    endtask

    // LOADV together with the terminal BITEN: new syllable starts, no DONE.
    task automatic test_load_on_last();
        expect_syllable(13'h1555, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1);
        expect_syllable(13'h0AAA, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if ({DONE, BUSY, SDATA} !== 3'b010 || PDATA !== exp_pdata || PERR !== exp_perr) begin
            failures++;
            $display("[TB] FAIL load_on_last: got done/busy/sdata=%b pdata=%h perr=%b expected 010 pdata=%h perr=%b", {DONE, BUSY, SDATA}, PDATA, PERR, exp_pdata, exp_perr);
        end
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int dones;
        expect_syllable(13'h1FFF, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if ({SDATA, BUSY, DONE, PERR} !== 4'b0000 || PDATA !== 13'h0000) begin
            failures++;
            $display("[TB] FAIL reset_mid: got sdata/busy/done/perr=%b pdata=%h expected 0000 pdata=0000", {SDATA, BUSY, DONE, PERR}, PDATA);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            if (DONE !== 1'b0 || BUSY !== 1'b0 || SDATA !== 1'b0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_biten_ignored: got %0d active cycles expected 0", dones);
        end
    endtask

    initial begin
        reset = 1'b1;
        LOADV = 1'b0;
        BITEN = 1'b0;
        syl   = 14'h0000;

        test_reset();
        test_stream("alt1555", 13'h1555, 1'b0, 0);
        test_stream("zero", 13'h0000, 1'b0, 0);
        test_restart();
        test_load_on_last();
        test_reset_mid();
        test_stream("spaced0aaa", 13'h0AAA, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
